shift_unit_iter: RTL and testbench

Multi-cycle, parametrised integer shifter for the RV64 execute stage. It implements SLL/SRL/SRA and the 32-bit word variants SLLW/SRLW/SRAW. It consumes at most STEP bit positions per cycle, so area stays small compared with a full barrel shifter. It sits beside the ALU behind a valid/ready handshake and returns one XLEN-bit result per accepted operation.

---
 rtl/shift_unit_iter_pkg.sv | 16 +
 rtl/shift_unit_iter_if.sv | 24 ++
 rtl/shift_unit_iter_step.sv | 16 +
 rtl/shift_unit_iter.sv | 99 +++++++++
 tb/tb_shift_unit_iter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/shift_unit_iter_pkg.sv
// shift_pkg: shared opcodes, FSM states and default widths for the iterative shifter
package shift_pkg;
  localparam int XLEN_DEF = 64;
  localparam int STEP_DEF = 8;
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_RSVD = 2'b10,
    OP_SRA  = 2'b11
  } shift_op_e;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;
endpackage

// File: rtl/shift_unit_iter_if.sv
// shift_unit_iter_if: request/response handshake bundle between the ALU issue logic and the shifter
interface shift_unit_iter_if import shift_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [SHW-1:0]  shamt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  modport master (
    output in_valid, op, word, a, shamt, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  in_valid, op, word, a, shamt, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/shift_unit_iter_step.sv
// shift_step: combinational shifter bounded to at most STEP positions per use
module shift_step #(
  parameter int XLEN = 64,
  parameter int STEP = 8,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] w_i,
  input  logic [KW-1:0]   k_i,
  input  logic            left_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] y_o
);
  always_comb y_o = left_i  ? w_i << k_i :
                    arith_i ? $unsigned($signed(w_i) >>> k_i) :
                              w_i >> k_i;
endmodule

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle RV64 SLL/SRL/SRA(+W) shifter consuming up to STEP positions per cycle
module shift_unit_iter import shift_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int STEP = STEP_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic clk,
  input logic rst_n,
  shift_unit_iter_if.slave bus
);
  localparam int KW = $clog2(STEP + 1);
  state_e          state_q, state_d;
  shift_op_e       op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] w_q, w_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] prep, step_y;
  logic [SHW-1:0]  s;
  logic [KW-1:0]   k;

  function automatic logic [XLEN-1:0] word_ext(input logic wd, input logic [XLEN-1:0] v);
    return wd ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Word ops only see the low five shamt bits and a 32-bit operand, pre-extended for SRAW
  assign s    = bus.word ? SHW'(bus.shamt[4:0]) : bus.shamt;
  assign prep = !bus.word ? bus.a : {{(XLEN-32){(bus.op == OP_SRA) & bus.a[31]}}, bus.a[31:0]};
  assign k    = (int'(rem_q) > STEP) ? KW'(STEP) : KW'(rem_q);

  shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .w_i    (w_q),
    .k_i    (k),
    .left_i (!op_q[0]),
    .arith_i(op_q == OP_SRA),
    .y_o    (step_y)
  );

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.busy      = state_q != IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    w_d         = w_q;
    rem_d       = rem_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        op_d        = shift_op_e'(bus.op);
        word_d      = bus.word;
        w_d         = prep;
        rem_d       = s;
        state_d     = (s != '0) ? SHIFT : DONE;
        out_valid_d = (s == '0);
        result_d    = (s == '0) ? word_ext(bus.word, prep) : result_q;
      end
      SHIFT: begin
        w_d   = step_y;
        rem_d = rem_q - SHW'(k);
        if (rem_d == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = word_ext(word_q, step_y);
        end
      end
      DONE: if (bus.out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_SLL;
      word_q      <= 1'b0;
      w_q         <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      word_q      <= word_d;
      w_q         <= w_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed and randomized checks of shift_unit_iter against an arithmetic reference
module tb_shift_unit_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   due = 0;
  bit   pending = 1'b0;
  bit   after_rst = 1'b0;
  logic [63:0] m_res = '0;

  shift_unit_iter_if #(.XLEN(64)) bus ();
  shift_unit_iter #(.XLEN(64), .STEP(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic int eff_s(input logic word, input logic [5:0] sh);
    return word ? int'(sh[4:0]) : int'(sh);
  endfunction

  function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [5:0] sh);
    int s;
    logic [63:0] x, r;
    s = eff_s(word, sh);
    x = !word ? a : (op == 2'b11 ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]});
    r = op == 2'b01 ? x >> s : op == 2'b11 ? $unsigned($signed(x) >>> s) : x << s;
    return word ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  // Reference: one in-flight op, result due 1+ceil(s/8) cycles after acceptance, held until taken
  always @(negedge clk) begin
    cyc++;
    chk("in_ready", {63'b0, bus.in_ready}, {63'b0, rst_n && !pending});
    chk("busy", {63'b0, bus.busy}, {63'b0, pending});
    chk("out_valid", {63'b0, bus.out_valid}, {63'b0, pending && cyc >= due});
    if (pending && cyc >= due) chk("result", bus.result, m_res);
    if (after_rst) chk("rst_result", bus.result, 64'h0);
    after_rst = 1'b0;
    if (!rst_n) begin
      pending   = 1'b0;
      after_rst = 1'b1;
    end else if (!pending && bus.in_valid) begin
      pending = 1'b1;
      due     = cyc + 1 + (eff_s(bus.word, bus.shamt) + 7) / 8;
      m_res   = ref_shift(bus.op, bus.word, bus.a, bus.shamt);
    end else if (pending && cyc >= due && bus.out_ready) begin
      pending = 1'b0;
    end
  end

  task automatic scramble();
    bus.op    = 2'($urandom);
    bus.word  = 1'($urandom);
    bus.a     = {$urandom, $urandom};
    bus.shamt = 6'($urandom);
  endtask

  task automatic wait_accept(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
    end
    chk({"accept_", nm}, {63'b0, got}, 64'h1);
  endtask

  task automatic wait_result(input string nm, input logic [63:0] exp, input int exp_lat);
    int lat;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk({"lat_", nm}, 64'(lat), 64'(exp_lat));
    chk({"res_", nm}, bus.result, exp);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic word,
                        input logic [63:0] a, input logic [5:0] sh,
                        input logic [63:0] exp, input int exp_lat);
    bus.op = op; bus.word = word; bus.a = a; bus.shamt = sh; bus.in_valid = 1'b1;
    wait_accept(nm);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    scramble();
    wait_result(nm, exp, exp_lat);
    @(posedge clk); #2;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    scramble();
    chk("pin_srl", ref_shift(2'b01, 1'b0, 64'hF000_0000_0000_0000, 6'd4), 64'h0F00_0000_0000_0000);
    chk("pin_sraw", ref_shift(2'b11, 1'b1, 64'h0000_0000_8000_0000, 6'd4), 64'hFFFF_FFFF_F800_0000);
    chk("pin_sllw", ref_shift(2'b00, 1'b1, 64'h1, 6'd31), 64'hFFFF_FFFF_8000_0000);
    chk("pin_srlw33", ref_shift(2'b01, 1'b1, 64'h0000_0000_8000_0000, 6'd33), 64'h0000_0000_4000_0000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("srl4", 2'b01, 1'b0, 64'hF000_0000_0000_0000, 6'd4, 64'h0F00_0000_0000_0000, 2);
    run_op("sra63", 2'b11, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 9);
    run_op("srlw0", 2'b01, 1'b1, 64'h0000_0000_8000_0000, 6'd0, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("srlw33", 2'b01, 1'b1, 64'h0000_0000_8000_0000, 6'd33, 64'h0000_0000_4000_0000, 2);
    run_op("sllw31", 2'b00, 1'b1, 64'h1, 6'd31, 64'hFFFF_FFFF_8000_0000, 5);
    run_op("rsvdw31", 2'b10, 1'b1, 64'h1, 6'd31, 64'hFFFF_FFFF_8000_0000, 5);
    // Backpressure: a second request waits on in_valid until the held result retires
    bus.out_ready = 1'b0;
    bus.op = 2'b00; bus.word = 1'b0; bus.a = 64'h3; bus.shamt = 6'd2; bus.in_valid = 1'b1;
    wait_accept("bp1");
    @(posedge clk); #2;
    bus.op = 2'b01; bus.a = 64'h100; bus.shamt = 6'd8;
    wait_result("bp1", 64'hC, 2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", bus.result, 64'hC);
      chk("bp_valid", {63'b0, bus.out_valid}, 64'h1);
    end
    @(posedge clk); #2 bus.out_ready = 1'b1;
    @(negedge clk) chk("bp_ready_retire", {63'b0, bus.in_ready}, 64'h0);
    @(negedge clk) chk("bp_ready_after", {63'b0, bus.in_ready}, 64'h1);
    @(posedge clk); #2 bus.in_valid = 1'b0;
    wait_result("bp2", 64'h1, 2);
    @(posedge clk); #2;
    // Reset while an s=40 SRL is still shifting
    bus.op = 2'b01; bus.word = 1'b0; bus.a = 64'hDEAD_BEEF_0123_4567; bus.shamt = 6'd40; bus.in_valid = 1'b1;
    wait_accept("rst");
    @(posedge clk); #2 bus.in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {63'b0, bus.out_valid}, 64'h0);
    chk("rst_res", bus.result, 64'h0);
    chk("rst_busy", {63'b0, bus.busy}, 64'h0);
    chk("rst_ready", {63'b0, bus.in_ready}, 64'h1);
    @(posedge clk); #2;
    run_op("sll8", 2'b00, 1'b0, 64'h1, 6'd8, 64'h100, 2);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      bus.in_valid  = $urandom_range(0, 2) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      rst_n         = $urandom_range(0, 299) != 0;
      scramble();
    end
    @(posedge clk); #2;
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
